// File: rtl/bus_arbiter_n.sv
// N-master system-bus arbiter: registered one-hot grant plus binary mux select,
// fixed-priority or round-robin selection, optional per-tenure hold limit.
module bus_arbiter_n #(
    parameter int NUM_MASTERS = 4,
    parameter int NUM_SLAVES  = 3,
    parameter int RR_MODE     = 0,
    parameter int MAX_HOLD    = 0,
    localparam int MSEL_W     = (NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] breq,
    input  logic [NUM_SLAVES-1:0]  sready,
    output logic [NUM_MASTERS-1:0] bgrant,
    output logic [MSEL_W-1:0]      msel,
    output logic                   bus_busy,
    output logic                   timeout
);

    localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    logic [0:0]             state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [MSEL_W-1:0]      msel_q, msel_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic [MSEL_W-1:0]      ptr_q, ptr_d;
    logic [NUM_MASTERS-1:0] mask_q, mask_d;

    logic [NUM_MASTERS-1:0] elig;
    logic                   all_ready;
    logic                   owner_req;
    logic                   expire;
    logic [MSEL_W-1:0]      win;
    int unsigned            idx;

    assign elig      = breq & ~mask_q;
    assign all_ready = &sready;
    assign owner_req = |(breq & grant_q);
    assign expire    = (state_q == ST_GRANT) && (MAX_HOLD != 0) &&
                       (hold_q == HOLD_LAST) && owner_req;

    // Scan from lowest priority to highest so the last hit is the winner;
    // in round-robin the scan starts at the pointer and wraps.
    always_comb begin
        win = '0;
        idx = 0;
        for (int unsigned j = NUM_MASTERS; j > 0; j--) begin
            idx = ((RR_MODE != 0) ? 32'(ptr_q) : 32'd0) + j - 1;
            if (idx >= 32'(NUM_MASTERS)) begin
                idx = idx - 32'(NUM_MASTERS);
            end
            if (elig[idx]) begin
                win = MSEL_W'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        msel_d  = msel_q;
        hold_d  = hold_q;
        ptr_d   = ptr_q;
        mask_d  = mask_q;
        case (state_q)
            ST_IDLE: begin
                mask_d = '0;
                if ((|elig) && all_ready) begin
                    state_d      = ST_GRANT;
                    grant_d      = '0;
                    grant_d[win] = 1'b1;
                    msel_d       = win;
                    hold_d       = '0;
                    if (RR_MODE != 0) begin
                        ptr_d = (win == MSEL_W'(NUM_MASTERS - 1)) ? '0 : win + 1'b1;
                    end
                end
            end
            default: begin
                if (!owner_req) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    msel_d  = '0;
                    mask_d  = '0;
                end else if (expire) begin
                    // Bar the timed-out master from the single following arbitration.
                    state_d = ST_IDLE;
                    mask_d  = grant_q;
                    grant_d = '0;
                    msel_d  = '0;
                end else if (MAX_HOLD != 0) begin
                    hold_d = hold_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            msel_q  <= '0;
            hold_q  <= '0;
            ptr_q   <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            msel_q  <= msel_d;
            hold_q  <= hold_d;
            ptr_q   <= ptr_d;
            mask_q  <= mask_d;
        end
    end

    assign bgrant   = grant_q;
    assign msel     = msel_q;
    assign bus_busy = (state_q == ST_GRANT);
    assign timeout  = expire;

    a_onehot_grant: assert property (@(posedge clk) $onehot0(bgrant));
    a_timeout_busy: assert property (@(posedge clk) timeout |-> bus_busy);

endmodule

// File: tb/tb_bus_arbiter_n.sv
// Bench for bus_arbiter_n: four configurations checked every cycle against a
// rule-level model, plus directed scenarios with hand-computed expectations.
module tb_bus_arbiter_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0, rst1, rst2, rst3;
    logic [3:0] breq0, breq1, breq2;
    logic [1:0] breq3;
    logic [2:0] sready0, sready1, sready2;
    logic [1:0] sready3;
    logic [3:0] bg0, bg1, bg2;
    logic [1:0] bg3;
    logic [1:0] ms0, ms1, ms2;
    logic [0:0] ms3;
    logic       bb0, bb1, bb2, bb3;
    logic       to0, to1, to2, to3;

    bus_arbiter_n #(.NUM_MASTERS(4), .NUM_SLAVES(3), .RR_MODE(0), .MAX_HOLD(0)) u_fix (
        .clk(clk), .rst(rst0), .breq(breq0), .sready(sready0),
        .bgrant(bg0), .msel(ms0), .bus_busy(bb0), .timeout(to0));
    bus_arbiter_n #(.NUM_MASTERS(4), .NUM_SLAVES(3), .RR_MODE(1), .MAX_HOLD(0)) u_rr (
        .clk(clk), .rst(rst1), .breq(breq1), .sready(sready1),
        .bgrant(bg1), .msel(ms1), .bus_busy(bb1), .timeout(to1));
    bus_arbiter_n #(.NUM_MASTERS(4), .NUM_SLAVES(3), .RR_MODE(0), .MAX_HOLD(4)) u_to (
        .clk(clk), .rst(rst2), .breq(breq2), .sready(sready2),
        .bgrant(bg2), .msel(ms2), .bus_busy(bb2), .timeout(to2));
    bus_arbiter_n #(.NUM_MASTERS(2), .NUM_SLAVES(2), .RR_MODE(0), .MAX_HOLD(0)) u_cmp (
        .clk(clk), .rst(rst3), .breq(breq3), .sready(sready3),
        .bgrant(bg3), .msel(ms3), .bus_busy(bb3), .timeout(to3));

    logic       rst_v    [4];
    logic [3:0] breq_v   [4];
    logic [2:0] sready_v [4];
    logic [3:0] bg_v     [4];
    logic [1:0] ms_v     [4];
    logic       bb_v     [4];
    logic       to_v     [4];

    always_comb begin
        rst_v[0] = rst0;  rst_v[1] = rst1;  rst_v[2] = rst2;  rst_v[3] = rst3;
        breq_v[0] = breq0; breq_v[1] = breq1; breq_v[2] = breq2; breq_v[3] = {2'b00, breq3};
        sready_v[0] = sready0; sready_v[1] = sready1; sready_v[2] = sready2;
        sready_v[3] = {1'b1, sready3};
        bg_v[0] = bg0; bg_v[1] = bg1; bg_v[2] = bg2; bg_v[3] = {2'b00, bg3};
        ms_v[0] = ms0; ms_v[1] = ms1; ms_v[2] = ms2; ms_v[3] = {1'b0, ms3};
        bb_v[0] = bb0; bb_v[1] = bb1; bb_v[2] = bb2; bb_v[3] = bb3;
        to_v[0] = to0; to_v[1] = to1; to_v[2] = to2; to_v[3] = to3;
    end

    int nm [4] = '{4, 4, 4, 2};
    int rrm[4] = '{0, 1, 0, 0};
    int mh [4] = '{0, 0, 4, 0};

    int n_checks = 0;
    int n_pass   = 0;
    bit started  = 1'b0;

    // Model state: who owns the bus, how many cycles it has held it, the
    // round-robin start point and the master barred from the next arbitration.
    bit m_busy[4] = '{default: 1'b0};
    int m_own [4] = '{default: 0};
    int m_held[4] = '{default: 0};
    int m_ptr [4] = '{default: 0};
    int m_ban [4] = '{default: -1};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [3:0] x_grant(input int id);
        if (m_busy[id]) return 4'(1 << m_own[id]);
        return 4'b0000;
    endfunction

    function automatic logic [1:0] x_msel(input int id);
        return m_busy[id] ? 2'(m_own[id]) : 2'b00;
    endfunction

    function automatic logic x_timeout(input int id);
        return m_busy[id] && (mh[id] > 0) && (m_held[id] == mh[id] - 1) &&
               breq_v[id][m_own[id]];
    endfunction

    always @(posedge clk) begin
        started <= 1'b1;
        for (int id = 0; id < 4; id++) begin
            int n, w, k;
            bit found;
            logic [3:0] elig;
            n = nm[id];
            if (rst_v[id]) begin
                m_busy[id] <= 1'b0;
                m_held[id] <= 0;
                m_ptr[id]  <= 0;
                m_ban[id]  <= -1;
            end else if (m_busy[id]) begin
                if (!breq_v[id][m_own[id]]) begin
                    m_busy[id] <= 1'b0;
                    m_ban[id]  <= -1;
                end else if (mh[id] > 0 && m_held[id] == mh[id] - 1) begin
                    m_busy[id] <= 1'b0;
                    m_ban[id]  <= m_own[id];
                end else begin
                    m_held[id] <= m_held[id] + 1;
                end
            end else begin
                m_ban[id] <= -1;
                elig = breq_v[id];
                if (m_ban[id] >= 0) elig[m_ban[id]] = 1'b0;
                found = 1'b0;
                w = 0;
                for (int j = 0; j < n; j++) begin
                    k = (rrm[id] != 0) ? (m_ptr[id] + j) % n : j;
                    if (!found && elig[k]) begin
                        found = 1'b1;
                        w = k;
                    end
                end
                if (found && sready_v[id] == 3'b111) begin
                    m_busy[id] <= 1'b1;
                    m_own[id]  <= w;
                    m_held[id] <= 0;
                    if (rrm[id] != 0) m_ptr[id] <= (w + 1) % n;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            for (int id = 0; id < 4; id++) begin
                check($sformatf("m%0d_bgrant", id), 32'(bg_v[id]), 32'(x_grant(id)));
                check($sformatf("m%0d_msel", id), 32'(ms_v[id]), 32'(x_msel(id)));
                check($sformatf("m%0d_busy", id), 32'(bb_v[id]), 32'(m_busy[id]));
                check($sformatf("m%0d_timeout", id), 32'(to_v[id]), 32'(x_timeout(id)));
                check($sformatf("m%0d_onehot", id), 32'($onehot0(bg_v[id])), 32'd1);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_fixed();
        breq0 = 4'b1010;
        tick();
        check("fix_grant1", 32'(bg0), 32'h2);
        check("fix_msel1", 32'(ms0), 32'd1);
        check("mdl_fix_grant1", 32'(x_grant(0)), 32'h2);
        breq0 = 4'b1000;
        tick();
        check("fix_gap", 32'(bg0), 32'h0);
        tick();
        check("fix_grant3", 32'(bg0), 32'h8);
        check("fix_msel3", 32'(ms0), 32'd3);
        breq0 = 4'b0000;
        tick(2);
        breq0 = 4'b0001;
        sready0 = 3'b101;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("srdy_blocked", 32'(bg0), 32'h0);
        end
        sready0 = 3'b111;
        tick();
        check("srdy_grant", 32'(bg0), 32'h1);
        sready0 = 3'b000;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("srdy_hold", 32'(bg0), 32'h1);
            check("srdy_busy", 32'(bb0), 32'd1);
        end
        breq0 = 4'b0000;
        sready0 = 3'b111;
        tick(2);
    endtask

    task automatic run_rr();
        breq1 = 4'b1111;
        tick();
        for (int k = 0; k < 5; k++) begin
            check("rr_grant", 32'(bg1), 32'(1 << (k % 4)));
            check("rr_msel", 32'(ms1), 32'(k % 4));
            check("mdl_rr_grant", 32'(x_grant(1)), 32'(1 << (k % 4)));
            tick();
            check("rr_second", 32'(bg1), 32'(1 << (k % 4)));
            breq1[k % 4] = 1'b0;
            tick();
            check("rr_idle", 32'(bg1), 32'h0);
            breq1 = 4'b1111;
            tick();
        end
        breq1 = 4'b0000;
        tick(2);
        // Pointer now at 2: granting master 2 leaves it at 3 before reset.
        breq1 = 4'b0100;
        tick();
        check("rst_pre_grant", 32'(bg1), 32'h4);
        breq1 = 4'b1100;
        rst1 = 1'b1;
        tick();
        check("rst_grant", 32'(bg1), 32'h0);
        check("rst_msel", 32'(ms1), 32'd0);
        check("rst_busy", 32'(bb1), 32'd0);
        rst1 = 1'b0;
        tick();
        check("rst_ptr_grant", 32'(bg1), 32'h4);
        check("rst_ptr_msel", 32'(ms1), 32'd2);
        breq1 = 4'b0000;
        tick(2);
    endtask

    task automatic run_timeout();
        breq2 = 4'b0011;
        tick();
        check("to_g0_first", 32'(bg2), 32'h1);
        check("to_none_first", 32'(to2), 32'd0);
        tick(2);
        check("to_none_third", 32'(to2), 32'd0);
        tick();
        check("to_g0_fourth", 32'(bg2), 32'h1);
        check("to_pulse0", 32'(to2), 32'd1);
        tick();
        check("to_idle0", 32'(bg2), 32'h0);
        check("to_idle0_pulse", 32'(to2), 32'd0);
        tick();
        check("to_g1", 32'(bg2), 32'h2);
        check("to_g1_msel", 32'(ms2), 32'd1);
        tick(3);
        check("to_pulse1", 32'(to2), 32'd1);
        check("to_g1_last", 32'(bg2), 32'h2);
        tick();
        check("to_idle1", 32'(bg2), 32'h0);
        tick();
        check("to_g0_again", 32'(bg2), 32'h1);
        check("to_g0_again_msel", 32'(ms2), 32'd0);
        tick(3);
        breq2 = 4'b0000;
        #1;
        check("to_drop_no_pulse", 32'(to2), 32'd0);
        check("to_drop_still_granted", 32'(bg2), 32'h1);
        tick();
        check("to_drop_idle", 32'(bg2), 32'h0);
        breq2 = 4'b0001;
        tick();
        check("to_drop_no_mask", 32'(bg2), 32'h1);
        breq2 = 4'b0000;
        tick(2);
    endtask

    task automatic run_compat();
        for (int i = 0; i < 10000; i++) begin
            breq3 = 2'($urandom_range(0, 3));
            sready3 = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
            tick();
        end
        breq3 = 2'b00;
        tick(2);
    endtask

    initial begin
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;
        breq0 = '0; breq1 = '0; breq2 = '0; breq3 = '0;
        sready0 = 3'b111; sready1 = 3'b111; sready2 = 3'b111; sready3 = 2'b11;
        tick(2);
        check("reset_grant", 32'(bg0), 32'h0);
        check("reset_msel", 32'(ms0), 32'd0);
        check("reset_busy", 32'(bb0), 32'd0);
        check("reset_timeout", 32'(to2), 32'd0);
        check("reset_grant_cmp", 32'(bg3), 32'h0);
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0; rst3 = 1'b0;
        fork
            begin
                run_fixed();
                run_rr();
                run_timeout();
            end
            run_compat();
        join
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
